// File: rtl/vga_timing_gen.sv
// vga_timing_gen: divides the board clock down to the pixel rate. It produces the raster
// counters, sync, blanking and frame-start strobes for a 640x480@60 display. The counters
// lead bright/hSync/vSync by PIPE_DELAY pixel ticks. This lets a downstream glyph fetch with
// a fixed read latency line up with the delayed sync and blanking at the colour mux.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pixelTick,
  output logic [15:0] hCount,
  output logic [15:0] vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] HS_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [15:0]      h_q, h_d;
  logic [15:0]      v_q, v_d;
  logic             bright_raw, hsync_raw, vsync_raw;

  // Next-state logic: the divider wraps at CLK_DIV-1; the raster advances only on a pixel tick
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d = (div_q == DIV_LAST);
    h_d    = h_q;
    v_d    = v_q;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
    end
  end

  // Divider, tick strobe and raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      v_q    <= v_d;
    end
  end

  // Undelayed decode of the current raster position (syncs are active low)
  always_comb begin
    bright_raw = (h_q < H_VIS) && (v_q < V_VIS);
    hsync_raw  = !((h_q >= HS_START) && (h_q < HS_END));
    vsync_raw  = !((v_q >= VS_START) && (v_q < VS_END));
  end

  assign pixelTick  = tick_q;
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign frameStart = tick_q && (h_q == H_LAST) && (v_q == V_LAST);

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      // The counters are already zero during reset, which would decode as visible. This flag
      // holds the outputs inactive until the first clock after reset is released.
      logic run_q;

      // Marks the clocks that follow reset release
      always_ff @(posedge clk) begin
        run_q <= !reset;
      end

      assign bright = run_q ? bright_raw : 1'b0;
      assign hSync  = run_q ? hsync_raw  : 1'b1;
      assign vSync  = run_q ? vsync_raw  : 1'b1;
    end else begin : g_delay
      // Each stage holds {bright, hSync, vSync}. Stage 0 takes the current decode.
      logic [2:0] dly_q [PIPE_DELAY];

      // Shift the decode through the delay line once per pixel tick. Reset flushes it to
      // inactive so that no stale pixel is emitted after reset is released.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= 3'b011;
        end else if (tick_q) begin
          dly_q[0] <= {bright_raw, hsync_raw, vsync_raw};
          for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign bright = dly_q[PIPE_DELAY-1][2];
      assign hSync  = dly_q[PIPE_DELAY-1][1];
      assign vSync  = dly_q[PIPE_DELAY-1][0];
    end
  endgenerate

endmodule
